fifo_credit_arbiter: RTL

//  Write-side scheduler for async_fifo_credit: shares one FIFO write port between N requesters.

---
 rtl/fifo_arb_pkg.sv | 11 +
 rtl/rr_priority_pick.sv | 25 ++
 rtl/fifo_credit_arbiter.sv | 86 ++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the credit-based FIFO write arbiter
package fifo_arb_pkg;
  localparam int MAX_REQ = 8;
  localparam int MAX_CREDIT_W = 16;
  typedef enum logic {IDLE, HOLD} arb_state_e;
  typedef logic [$clog2(MAX_REQ)-1:0] req_idx_t;
  typedef logic [MAX_CREDIT_W-1:0] credit_t;
  function automatic int wrap_inc(input int i, input int n);
    return (i + 1) % n;
  endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: rotate-priority picker, first set request at or after ptr wins
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    onehot = '0;
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        onehot = '0;
        onehot[(int'(ptr) + k) % N] = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_credit_arbiter.sv
// fifo_credit_arbiter: round-robin, burst-bounded, credit-gated sharing of one FIFO write port
module fifo_credit_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int BURST  = 4
) (
  input  logic                       wr_clk,
  input  logic                       wr_rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       fifo_wr_valid,
  output logic [DATA_W-1:0]          fifo_wr_data,
  input  logic                       fifo_credit_pulse,
  output logic [$clog2(DEPTH+1)-1:0] credits,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       credit_err
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(N_REQ);
  localparam int BW = $clog2(BURST + 1);
  if (N_REQ < 2 || N_REQ > MAX_REQ) begin : g_bad_n
    $error("N_REQ out of range");
  end
  arb_state_e state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt, pick_idx, sel;
  logic [N_REQ-1:0] pick_oh;
  logic [BW-1:0] burst_cnt;
  logic pick_any, sel_valid, accept, burst_end, full;
  rr_priority_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req(req_valid),
    .ptr(ptr),
    .onehot(pick_oh),
    .idx(pick_idx),
    .any(pick_any)
  );
  // In HOLD the owner keeps priority even when stalled on credits
  assign sel = state == HOLD ? grant_id : pick_idx;
  assign sel_valid = state == HOLD ? req_valid[grant_id] : pick_any;
  assign accept = |(req_valid & req_ready);
  assign full = credits == CW'(DEPTH);
  assign burst_end = state == IDLE ? BURST == 1 : burst_cnt == BW'(BURST - 1);
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state <= IDLE;
      ptr <= '0;
      grant_id <= '0;
      burst_cnt <= '0;
      credits <= CW'(DEPTH);
      credit_err <= 1'b0;
      fifo_wr_valid <= 1'b0;
      fifo_wr_data <= '0;
    end else begin
      state <= state_nxt;
      ptr <= ptr_nxt;
      if (accept && state == IDLE) begin
        grant_id <= pick_idx;
        burst_cnt <= BW'(1);
      end else if (accept) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
      credits <= full && fifo_credit_pulse && !accept ? credits
               : credits - CW'(accept) + CW'(fifo_credit_pulse);
      credit_err <= credit_err | (full & fifo_credit_pulse);
      fifo_wr_valid <= accept;
      if (accept) fifo_wr_data <= req_data[int'(sel)*DATA_W +: DATA_W];
    end
  end
  always_comb begin
    state_nxt = state;
    ptr_nxt = ptr;
    if ((accept && burst_end) || (state == HOLD && !req_valid[grant_id])) begin
      state_nxt = IDLE;
      ptr_nxt = IW'(wrap_inc(int'(sel), N_REQ));
    end else if (accept) begin
      state_nxt = HOLD;
    end
  end
  always_comb begin
    req_ready = '0;
    if (credits != '0 && sel_valid) req_ready = state == IDLE ? pick_oh : N_REQ'(1) << grant_id;
  end
endmodule
